// File: rtl/csm_pkg.sv
// Shared types and constants for the sequential carry-save multiplier.
package csm_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  localparam int NIB_W      = 4;
  localparam int CORE_OUT_W = 9;

  // Ceiling log2 with a floor of 1 so a counter is never zero bits wide.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/multiCS4.sv
// Combinational 4x4 unsigned multiplier: two carry-save rows then one carry-propagate add.
module multiCS4
  import csm_pkg::*;
(
  input  logic [NIB_W-1:0]      i_a,
  input  logic [NIB_W-1:0]      i_b,
  output logic [CORE_OUT_W-1:0] o_p
);
  logic [NIB_W-1:0][2*NIB_W-1:0] w_pp;
  logic [2*NIB_W-1:0] w_s1, w_c1, w_s2, w_c2;

  for (genvar r = 0; r < NIB_W; r++) begin : g_pp
    assign w_pp[r] = (2*NIB_W)'({NIB_W{i_b[r]}} & i_a) << r;
  end

  assign w_s1 = w_pp[0] ^ w_pp[1] ^ w_pp[2];
  assign w_c1 = ((w_pp[0] & w_pp[1]) | (w_pp[0] & w_pp[2]) | (w_pp[1] & w_pp[2])) << 1;
  assign w_s2 = w_s1 ^ w_c1 ^ w_pp[3];
  assign w_c2 = ((w_s1 & w_c1) | (w_s1 & w_pp[3]) | (w_c1 & w_pp[3])) << 1;

  assign o_p = CORE_OUT_W'(w_s2) + CORE_OUT_W'(w_c2);
endmodule

// File: rtl/csm_mult_seq.sv
// Iterative WIDTH x WIDTH unsigned multiplier time-sharing one 4x4 core.
module csm_mult_seq
  import csm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   factor1,
  input  logic [WIDTH-1:0]   factor2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);
  localparam int N     = WIDTH / NIB_W;
  localparam int STEPS = N * N;
  localparam int W2    = 2 * WIDTH;
  localparam int CNT_W = clog2(STEPS + 1);
  localparam int IDX_W = clog2(N);
  localparam int SH_W  = clog2(2 * N);

  state_e r_state, w_state_nxt;

  logic [WIDTH-1:0]      r_opa, r_opb;
  logic [W2-1:0]         r_acc;
  logic [CNT_W-1:0]      r_step;
  logic [IDX_W-1:0]      r_i, r_j;
  logic [NIB_W-1:0]      r_na, r_nb;
  logic [SH_W-1:0]       r_sh;
  logic                  r_sel_vld;

  logic [NIB_W-1:0]      w_nib_a, w_nib_b;
  logic [SH_W-1:0]       w_sh_nxt;
  logic [CORE_OUT_W-1:0] w_core;
  logic [W2-1:0]         w_pp;
  logic                  w_last;
  logic                  w_unused;

  // Nibble selects are registered, so the add for step k lands one cycle after its select;
  // r_step therefore runs 0..STEPS and the final add coincides with r_step == STEPS.
  assign w_nib_a  = NIB_W'(r_opa >> (NIB_W * 32'(r_i)));
  assign w_nib_b  = NIB_W'(r_opb >> (NIB_W * 32'(r_j)));
  assign w_sh_nxt = SH_W'(32'(r_i) + 32'(r_j));
  assign w_last   = (r_step == CNT_W'(STEPS));

  multiCS4 u_core (
    .i_a (r_na),
    .i_b (r_nb),
    .o_p (w_core)
  );

  // Bit 8 of a 4x4 product is always zero.
  assign w_unused = w_core[CORE_OUT_W-1];
  assign w_pp     = W2'(w_core[2*NIB_W-1:0]) << (NIB_W * 32'(r_sh));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = CALC;
      CALC:    if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opa     <= '0;
      r_opb     <= '0;
      r_acc     <= '0;
      r_step    <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_na      <= '0;
      r_nb      <= '0;
      r_sh      <= '0;
      r_sel_vld <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_opa     <= factor1;
          r_opb     <= factor2;
          r_acc     <= '0;
          r_step    <= '0;
          r_i       <= '0;
          r_j       <= '0;
          r_sel_vld <= 1'b0;
        end
        CALC: begin
          if (r_sel_vld) r_acc <= r_acc + w_pp;
          if (!w_last) begin
            r_na      <= w_nib_a;
            r_nb      <= w_nib_b;
            r_sh      <= w_sh_nxt;
            r_sel_vld <= 1'b1;
            r_step    <= r_step + 1'b1;
            if (r_j == IDX_W'(N - 1)) begin
              r_j <= '0;
              r_i <= r_i + 1'b1;
            end else begin
              r_j <= r_j + 1'b1;
            end
          end else begin
            r_sel_vld <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign product   = r_acc;
endmodule
